// File: rtl/rect_copy_controller.sv
// rect_copy_controller: streams rect records from data memory to the GPU, resolving relative x/y into absolute coordinates.
module rect_copy_controller #(
    parameter int RECT_COUNT = 64,
    parameter int RECT_BASE  = 0,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [15:0]           mem_rdata,
    output logic                  copy_start,
    output logic [15:0]           gpu_data,
    output logic                  busy,
    output logic                  done
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2;
    localparam int CW = $clog2(6 * RECT_COUNT) + 1;
    localparam logic [CW-1:0] LAST = CW'(6 * RECT_COUNT - 1);

    logic [1:0]    state;
    logic [CW-1:0] k;
    logic [2:0]    islot, dslot;
    logic          dvalid, rel;
    logic [15:0]   cur_x, cur_y, prev_x, prev_y, sum;

    assign busy = state != IDLE;
    assign sum = mem_rdata + (rel ? (dslot == 3'd1 ? prev_x : prev_y) : 16'd0);
    // Data slots trail the address slots by the one-cycle memory latency.
    assign gpu_data = (!dvalid || dslot == 3'd0) ? 16'd0 : (dslot <= 3'd2 ? sum : mem_rdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            islot      <= 3'd0;
            dslot      <= 3'd0;
            dvalid     <= 1'b0;
            rel        <= 1'b0;
            cur_x      <= 16'd0;
            cur_y      <= 16'd0;
            prev_x     <= 16'd0;
            prev_y     <= 16'd0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            copy_start <= 1'b0;
            done       <= 1'b0;
        end else begin
            copy_start <= 1'b0;
            done       <= 1'b0;
            dvalid     <= mem_re;
            dslot      <= islot;
            if (dvalid) begin
                case (dslot)
                    3'd0: rel <= mem_rdata[0];
                    3'd1: cur_x <= sum;
                    3'd2: cur_y <= sum;
                    3'd5: begin
                        prev_x <= cur_x;
                        prev_y <= cur_y;
                    end
                    default: ;
                endcase
            end
            case (state)
                IDLE: if (start) begin
                    state      <= ISSUE;
                    copy_start <= 1'b1;
                    mem_re     <= 1'b1;
                    mem_addr   <= ADDR_WIDTH'(RECT_BASE);
                    k          <= '0;
                    islot      <= 3'd0;
                    prev_x     <= 16'd0;
                    prev_y     <= 16'd0;
                end
                ISSUE: if (k == LAST) begin
                    state    <= DRAIN;
                    mem_re   <= 1'b0;
                    mem_addr <= '0;
                end else begin
                    k        <= k + 1'b1;
                    mem_addr <= mem_addr + 1'b1;
                    islot    <= islot == 3'd5 ? 3'd0 : islot + 3'd1;
                end
                DRAIN: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
